// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: pairs PCLK-domain bytes into pixels and emits linear frame-buffer writes.
// Optional CAPTURE_DECIMATE_EN keeps only even pixels of even lines (2x2 decimation).
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_24,
    input  logic              rst_n,
    input  logic              config_finished,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic [7:0]        frame_cnt
);

`ifdef CAPTURE_DECIMATE_EN
    localparam int MAX_PIX = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
    localparam int MAX_PIX = H_ACTIVE * V_ACTIVE;
`endif
    localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(MAX_PIX);
    localparam logic [15:0]       H_LIM     = 16'(H_ACTIVE);
    localparam logic [15:0]       V_LIM     = 16'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_VS, SYNC, CAPTURE} state_t;

    state_t            state, state_nx;
    logic              rst_meta, rst_sync_n;
    logic              vs_r, vs_q, href_r, href_q;
    logic [7:0]        d_r, hi;
    logic              phase;
    logic [15:0]       pix_cnt, line_cnt;
    logic [ADDR_W-1:0] px_idx;
    logic              start, fin, active, keep, vs_rise, vs_fall, href_fall;

    // Async assert, synchronous release of the internal reset
    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    always_ff @(posedge clk_24 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vs_r   <= 1'b0;
            vs_q   <= 1'b0;
            href_r <= 1'b0;
            href_q <= 1'b0;
            d_r    <= 8'd0;
        end else begin
            vs_r   <= vsync;
            vs_q   <= vs_r;
            href_r <= href;
            href_q <= href_r;
            d_r    <= d;
        end
    end

    assign vs_rise   = vs_r & ~vs_q;
    assign vs_fall   = ~vs_r & vs_q;
    assign href_fall = ~href_r & href_q;

`ifdef CAPTURE_DECIMATE_EN
    assign keep = ~line_cnt[0] & ~pix_cnt[0];
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge clk_24 or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        fin      = 1'b0;
        if (!config_finished) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = WAIT_VS;
                WAIT_VS: if (vs_r) state_nx = SYNC;
                SYNC:    if (vs_fall) begin
                    state_nx = CAPTURE;
                    start    = 1'b1;
                end
                CAPTURE: if (vs_rise) begin
                    state_nx = SYNC;
                    fin      = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // A vsync rise ends the frame this cycle, so no write can coincide with frame_done
    assign active = (state == CAPTURE) && config_finished && !vs_rise;

    always_ff @(posedge clk_24 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 16'd0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_cnt  <= 8'd0;
            hi         <= 8'd0;
            phase      <= 1'b0;
            pix_cnt    <= 16'd0;
            line_cnt   <= 16'd0;
            px_idx     <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= fin;
            if (start) begin
                wr_addr  <= '0;
                px_idx   <= '0;
                pix_cnt  <= 16'd0;
                line_cnt <= 16'd0;
                line_err <= 1'b0;
                phase    <= 1'b0;
            end
            if (fin) begin
                frame_cnt <= frame_cnt + 8'd1;
                phase     <= 1'b0;
                pix_cnt   <= 16'd0;
            end
            if (active) begin
                if (href_r) begin
                    if (!phase) begin
                        hi    <= d_r;
                        phase <= 1'b1;
                    end else begin
                        phase   <= 1'b0;
                        pix_cnt <= pix_cnt + {15'd0, pix_cnt != 16'hFFFF};
                        if (keep && line_cnt < V_LIM && pix_cnt < H_LIM && px_idx < PIX_LIMIT) begin
                            wr_en   <= 1'b1;
                            wr_data <= {hi, d_r};
                            wr_addr <= px_idx;
                            px_idx  <= px_idx + 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    // Odd trailing byte is dropped by resetting the phase
                    phase    <= 1'b0;
                    pix_cnt  <= 16'd0;
                    line_cnt <= line_cnt + {15'd0, line_cnt != 16'hFFFF};
                    if (pix_cnt != H_LIM) line_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a reduced 8x6 geometry; honours CAPTURE_DECIMATE_EN.
module tb_ov7670_capture;
    localparam int H  = 8;
    localparam int V  = 6;
    localparam int AW = 6;
`ifdef CAPTURE_DECIMATE_EN
    localparam int MAXP = (H / 2) * (V / 2);
`else
    localparam int MAXP = H * V;
`endif

    logic          clk_24 = 1'b0;
    logic          rst_n = 1'b0;
    logic          config_finished = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    d = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          line_err;
    logic [7:0]    frame_cnt;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk_24(clk_24), .rst_n(rst_n), .config_finished(config_finished),
        .vsync(vsync), .href(href), .d(d),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .line_err(line_err), .frame_cnt(frame_cnt)
    );

    always #5 clk_24 = ~clk_24;

    typedef struct {int addr; int data;} exp_t;
    exp_t sb[$];
    exp_t e;

    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   exp_done = 0;
    int   exp_cnt = 0;
    int   m_idx = 0;
    int   m_line = 0;
    bit   m_err = 0;
    bit   armed = 0;
    logic [7:0] hi_b = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit keep(input int l, input int p);
`ifdef CAPTURE_DECIMATE_EN
        return (l % 2 == 0) && (p % 2 == 0);
`else
        return (l >= 0) && (p >= 0);
`endif
    endfunction

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk_24) begin
        if (rst_n) begin
            if (wr_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h, none expected", wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_data", int'(wr_data), e.data);
                end
            end
            if (frame_done) begin
                done_seen++;
                chk("done_excl_wr", int'(wr_en), 0);
            end
        end
    end

    task automatic push_pixel(input int p, input logic [15:0] px);
        if (armed && keep(m_line, p) && m_line < V && p < H && m_idx < MAXP) begin
            sb.push_back('{m_idx, int'(px)});
            m_idx++;
        end
    endtask

    task automatic send_bytes(input int nb);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk_24);
            href = 1'b1;
            d = 8'($urandom);
            if (b % 2 == 0) hi_b = d;
            else push_pixel(b / 2, {hi_b, d});
        end
    endtask

    task automatic line_end(input int npix);
        if (armed) begin
            if (npix != H) m_err = 1'b1;
            m_line++;
        end
    endtask

    task automatic send_line(input int npix, input bit odd);
        send_bytes(2 * npix + int'(odd));
        @(negedge clk_24);
        href = 1'b0;
        line_end(npix);
        repeat (3) @(negedge clk_24);
    endtask

    // Frame boundary: ends the current frame (if armed) and opens the next
    task automatic vs_pulse();
        @(negedge clk_24);
        vsync = 1'b1;
        d = 8'($urandom);
        if (armed) begin
            exp_done++;
            exp_cnt = (exp_cnt + 1) % 256;
        end
        @(negedge clk_24);
        href = 1'b0;
        repeat (2) @(negedge clk_24);
        if (armed) chk("line_err_held", int'(line_err), int'(m_err));
        chk("frame_done_count", done_seen, exp_done);
        chk("frame_cnt", int'(frame_cnt), exp_cnt);
        vsync  = 1'b0;
        armed  = config_finished;
        m_idx  = 0;
        m_line = 0;
        m_err  = 1'b0;
        repeat (4) @(negedge clk_24);
        if (armed) chk("line_err_cleared", int'(line_err), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_24);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_line_err", int'(line_err), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_24);
        config_finished = 1'b1;
        repeat (4) @(negedge clk_24);
        vs_pulse();

        // Exact frame
        for (int l = 0; l < V; l++) send_line(H, 1'b0);
        vs_pulse();

        // Known pixel with explicit pin-to-strobe latency
        @(negedge clk_24);
        href = 1'b1; d = 8'hF8; hi_b = d;
        @(negedge clk_24);
        d = 8'h1F; push_pixel(0, 16'hF81F);
        @(negedge clk_24);
        href = 1'b0; line_end(1);
        chk("lat_early_wr_en", int'(wr_en), 0);
        @(negedge clk_24);
        chk("lat_wr_en", int'(wr_en), 1);
        chk("lat_wr_data", int'(wr_data), 16'hF81F);
        chk("lat_wr_addr", int'(wr_addr), 0);
        repeat (3) @(negedge clk_24);
        for (int l = 1; l < V; l++) send_line(H, 1'b0);
        vs_pulse();

        // Short line with an odd trailing byte
        send_line(H, 1'b0);
        send_line(H - 1, 1'b1);
        for (int l = 2; l < V; l++) send_line(H, 1'b0);
        vs_pulse();

        // Oversized frame: extra lines and extra pixels are not written
        for (int l = 0; l < V + 2; l++) send_line(H + 2, 1'b0);
        vs_pulse();

        // config_finished drops between lines
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        @(negedge clk_24);
        config_finished = 1'b0;
        armed = 1'b0;
        @(negedge clk_24);
        chk("cfg_drop_wr_en", int'(wr_en), 0);
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        vs_pulse();
        config_finished = 1'b1;
        repeat (4) @(negedge clk_24);
        vs_pulse();
        for (int l = 0; l < V; l++) send_line(H, 1'b0);
        vs_pulse();

        // vsync rises mid-line: partial pixel dropped, frame still completes
        send_line(H, 1'b0);
        send_bytes(5);
        vs_pulse();

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = int'($urandom_range(V + 2, 0));
            for (int l = 0; l < nl; l++)
                send_line(int'($urandom_range(H + 2, H - 2)), 1'($urandom_range(1, 0)));
            vs_pulse();
        end

        // Empty frames drive frame_cnt through its wrap
        for (int f = 0; f < 256; f++) vs_pulse();

        repeat (10) @(negedge clk_24);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
